// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_STATES wait cycles, then a RV32I byte/half/word access.
// Optional alignment checking is enabled by the macro DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [2:0]            r_func3;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_error;
  logic [31:0]           r_mem [0:(2**ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_word;
  logic                  w_access;
  logic                  w_illegal;
  logic                  w_misalign;
  logic                  w_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [3:0]            w_wmask;
  logic [31:0]           w_wval;
  logic                  w_unused_addr;

  // Upper address bits only matter for wrap-around, which falls out of truncation.
  assign w_unused_addr = &{1'b0, req_addr[31:ADDR_WIDTH+2]};

  assign w_idx    = r_addr[ADDR_WIDTH+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_error = r_error;

  always_comb begin
    w_illegal = 1'b0;
    if (r_write) begin
      w_illegal = !(r_func3 == 3'b000 || r_func3 == 3'b001 || r_func3 == 3'b010);
    end else begin
      w_illegal = (r_func3 == 3'b011 || r_func3 == 3'b110 || r_func3 == 3'b111);
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = ((r_func3[1:0] == 2'b01) && r_addr[0]) ||
                      ((r_func3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
  // Without checking, half/word accesses simply ignore the low address bits.
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_illegal || w_misalign;

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
    w_load = 32'h0;
    case (r_func3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = 32'h0;
    endcase
  end

  always_comb begin
    w_wmask = 4'b0000;
    w_wval  = r_wdata;
    case (r_func3)
      3'b000: begin
        w_wmask = 4'b0001 << r_addr[1:0];
        w_wval  = {4{r_wdata[7:0]}};
      end
      3'b001: begin
        w_wmask = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wval  = {2{r_wdata[15:0]}};
      end
      3'b010: begin
        w_wmask = 4'b1111;
        w_wval  = r_wdata;
      end
      default: begin
        w_wmask = 4'b0000;
        w_wval  = r_wdata;
      end
    endcase
  end

  // RAM is never cleared; rst only suppresses a store committing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && w_access && r_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wval[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_func3 <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_func3 <= req_func3;
            r_addr  <= req_addr[ADDR_WIDTH+1:0];
            r_wdata <= req_wdata;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_error <= w_err;
            r_rdata <= (r_write || w_err) ? 32'h0 : w_load;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the CPU load/store interface: accepts one data-memory request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then performs a RISC-V byte, halfword or word access on a word-organised RAM.
- Returns a one-cycle response carrying load data and an error flag.
- Intended to replace the zero-latency data memory behind the EX/MEM stage once the pipeline gains stall support.

Parameters:
- ADDR_WIDTH, 8, word-address bits; RAM depth = 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2, extra cycles spent in WAIT before the access; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  load result, extended per funct3; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid: illegal funct3 or misaligned access.
- busy  out  1  high in WAIT and RESP.

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, busy=0, wait counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clk edge with req_valid && req_ready, latch write, func3, addr and wdata.
  - Load the counter with WAIT_STATES and go to WAIT.
  - If req_valid is low, stay in IDLE.
- WAIT:
  - Counter != 0: decrement and stay in WAIT.
  - Counter == 0: perform the access on this edge, register the result, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. resp_rdata and resp_error hold their values until the next RESP.
- Latency:
  - Accept in cycle 0; resp_valid high in cycle WAIT_STATES+2; req_ready high again in cycle WAIT_STATES+3.
  - No back-to-back acceptance; maximum throughput is 1 request per WAIT_STATES+3 cycles.
- Addressing:
  - Word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so accesses wrap modulo the RAM size.
  - Byte lanes are little-endian: addr[1:0] selects the lane.
- Loads:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the half selected by addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected half.
- Stores:
  - 000 SB: write only the addressed byte lane.
  - 001 SH: write only the addressed half.
  - 010 SW: write the full word.
  - Other lanes are unchanged. A store returns resp_rdata=0.
- Errors:
  - Illegal funct3 (loads 011/110/111; stores anything other than 000/001/010): resp_error=1, resp_rdata=0, no RAM write.
  - Misaligned access (see Optional Feature): resp_error=1, resp_rdata=0, no RAM write.
- Input changes: changes on req_* while busy are ignored; only the latched copy is used.
- Reset mid-operation: rst has priority on every edge. A pending store that would commit on the same edge is dropped, and the FSM returns to IDLE with no resp_valid.
- Back-to-back requests: a request to the same word as the previous store observes the stored data.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1 is an error.
  - LW/SW with addr[1:0]!=0 is an error.
  - Error handling: resp_error=1, no write, resp_rdata=0.
- Undefined:
  - No alignment checking. Half accesses force addr[0] to 0; word accesses force addr[1:0] to 0.
  - The access proceeds normally; resp_error reflects only illegal funct3.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF; LW addr=0x10 -> resp_rdata=0xDEADBEEF, resp_error=0. With WAIT_STATES=2, resp_valid is seen exactly 4 cycles after each accept.
- After that word: LB addr=0x13 -> 0xFFFFFFDE; LBU addr=0x13 -> 0x000000DE; LH addr=0x10 -> 0xFFFFBEEF; LHU addr=0x12 -> 0x0000DEAD.
- SB addr=0x11 wdata=0x000000AA, then LW addr=0x10 -> 0xDEADAAEF. SH addr=0x12 wdata=0x1234, then LW -> 0x1234AAEF.
- LW addr=0x12:
  - With DMEM_MISALIGN_CHECK_EN -> resp_error=1, rdata=0.
  - Without the macro -> resp_error=0, rdata=word at 0x10.
  - Load funct3=011 -> resp_error=1 in both builds.
- Wrap: with ADDR_WIDTH=8, SW addr=0x400 wdata=0x55 -> LW addr=0x0 returns 0x00000055.
- rst asserted on the edge where an SW of 0xCAFEF00D to addr 0x20 would commit -> no resp_valid, state=IDLE, and a later LW 0x20 returns the prior contents.
